// File: rtl/player_controller.sv
// Player movement controller: debounces four direction buttons, queries the wall
// map for the target cell and commits legal moves until the goal cell is reached.
module player_controller #(
    parameter int GRID_W          = 16,
    parameter int GRID_H          = 12,
    parameter int COORD_W         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int START_X         = 0,
    parameter int START_Y         = 0,
    parameter int GOAL_X          = 15,
    parameter int GOAL_Y          = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btnU,
    input  logic               btnD,
    input  logic               btnL,
    input  logic               btnR,
    output logic               wall_req,
    output logic [COORD_W-1:0] wall_x,
    output logic [COORD_W-1:0] wall_y,
    input  logic               wall_is_wall,
    output logic [COORD_W-1:0] player_x,
    output logic [COORD_W-1:0] player_y,
    output logic [15:0]        move_count,
    output logic               won
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_ONE   = DB_W'(1);
    localparam logic [COORD_W:0]   C_ONE    = (COORD_W+1)'(1);
    localparam logic [COORD_W:0]   GRID_W_C = (COORD_W+1)'(GRID_W);
    localparam logic [COORD_W:0]   GRID_H_C = (COORD_W+1)'(GRID_H);
    localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] GOAL_XC  = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] GOAL_YC  = COORD_W'(GOAL_Y);

    // QUERY is the wall_req cycle; the registered wall map answers during WAIT.
    typedef enum logic [2:0] {IDLE, QUERY, WAIT, CHECK, WON} state_e;

    // Button vectors are ordered {U, D, L, R}, so higher index wins on ties.
    logic [3:0]      btn_raw;
    logic [3:0]      meta_q, sync_q, level_q, level_d, press_q;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];

    state_e             state_q, state_d;
    logic [COORD_W-1:0] player_x_q, player_x_d, player_y_q, player_y_d;
    logic [COORD_W-1:0] wall_x_q, wall_x_d, wall_y_q, wall_y_d;
    logic [15:0]        move_cnt_q, move_cnt_d;
    logic               won_q, won_d, wall_req_q, wall_req_d;
    logic [COORD_W:0]   cur_x, cur_y, tgt_x, tgt_y;
    logic               tgt_ok;

    assign btn_raw = {btnU, btnD, btnL, btnR};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) level_d[i] = ~level_q[i];
                else                        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            meta_q  <= btn_raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            press_q <= level_d & ~level_q;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    always_comb begin
        cur_x  = {1'b0, player_x_q};
        cur_y  = {1'b0, player_y_q};
        tgt_x  = cur_x;
        tgt_y  = cur_y;
        tgt_ok = 1'b1;
        if (press_q[3]) begin
            tgt_y  = cur_y - C_ONE;
            tgt_ok = (player_y_q != '0);
        end else if (press_q[2]) begin
            tgt_y  = cur_y + C_ONE;
            tgt_ok = (tgt_y < GRID_H_C);
        end else if (press_q[1]) begin
            tgt_x  = cur_x - C_ONE;
            tgt_ok = (player_x_q != '0);
        end else if (press_q[0]) begin
            tgt_x  = cur_x + C_ONE;
            tgt_ok = (tgt_x < GRID_W_C);
        end else begin
            tgt_ok = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        player_x_d = player_x_q;
        player_y_d = player_y_q;
        wall_x_d   = wall_x_q;
        wall_y_d   = wall_y_q;
        move_cnt_d = move_cnt_q;
        won_d      = won_q;
        wall_req_d = 1'b0;
        case (state_q)
            IDLE: if (tgt_ok) begin
                wall_x_d   = tgt_x[COORD_W-1:0];
                wall_y_d   = tgt_y[COORD_W-1:0];
                wall_req_d = 1'b1;
                state_d    = QUERY;
            end
            QUERY: state_d = WAIT;
            WAIT: begin
                if (wall_is_wall) begin
                    state_d = IDLE;
                end else begin
                    player_x_d = wall_x_q;
                    player_y_d = wall_y_q;
                    move_cnt_d = move_cnt_q + 16'd1;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (player_x_q == GOAL_XC && player_y_q == GOAL_YC) begin
                    won_d   = 1'b1;
                    state_d = WON;
                end else begin
                    state_d = IDLE;
                end
            end
            WON:     state_d = WON;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            player_x_q <= START_XC;
            player_y_q <= START_YC;
            wall_x_q   <= '0;
            wall_y_q   <= '0;
            move_cnt_q <= '0;
            won_q      <= 1'b0;
            wall_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            player_x_q <= player_x_d;
            player_y_q <= player_y_d;
            wall_x_q   <= wall_x_d;
            wall_y_q   <= wall_y_d;
            move_cnt_q <= move_cnt_d;
            won_q      <= won_d;
            wall_req_q <= wall_req_d;
        end
    end

    assign wall_req   = wall_req_q;
    assign wall_x     = wall_x_q;
    assign wall_y     = wall_y_q;
    assign player_x   = player_x_q;
    assign player_y   = player_y_q;
    assign move_count = move_cnt_q;
    assign won        = won_q;

endmodule

// File: tb/tb_player_controller.sv
// Bench for player_controller: directed scenarios plus random presses checked
// against a move-level model of the maze rules and a registered wall-map ROM.
module tb_player_controller;

    localparam int DB = 4;
    localparam int GW = 16;
    localparam int GH = 12;
    localparam int GOAL_X = 15;
    localparam int GOAL_Y = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
    logic       wall_req;
    logic [3:0] wall_x, wall_y, player_x, player_y;
    logic       wall_is_wall = 1'b0;
    logic [15:0] move_count;
    logic       won;

    int total = 0;
    int bad = 0;

    logic wall_map [0:GH-1][0:GW-1];

    int m_x, m_y, m_cnt;
    logic m_won;

    int   req_total = 0;
    logic [3:0] last_wx = '0, last_wy = '0;
    logic at_goal, at_goal_prev = 1'b0, won_pending = 1'b0;

    player_controller #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(4), .DEBOUNCE_CYCLES(DB),
        .START_X(0), .START_Y(0), .GOAL_X(GOAL_X), .GOAL_Y(GOAL_Y)
    ) dut (
        .clk(clk), .rst(rst),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_is_wall(wall_is_wall),
        .player_x(player_x), .player_y(player_y),
        .move_count(move_count), .won(won)
    );

    always #5 clk = ~clk;

    // Registered wall-map ROM: answer for the presented address one cycle later.
    always @(posedge clk)
        wall_is_wall <= (wall_y < 4'(GH)) ? wall_map[wall_y][wall_x] : 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    assign at_goal = (player_x == 4'(GOAL_X)) && (player_y == 4'(GOAL_Y));

    always @(negedge clk) begin
        if (wall_req) begin
            req_total <= req_total + 1;
            last_wx   <= wall_x;
            last_wy   <= wall_y;
        end
        if (won_pending) check("won_one_cycle_after_goal", won, 1);
        if (at_goal && !at_goal_prev && !rst) check("won_not_before_goal", won, 0);
        won_pending  <= at_goal && !at_goal_prev && !rst;
        at_goal_prev <= at_goal;
    end

    task automatic drive(input logic [3:0] mask);
        btnU = mask[3];
        btnD = mask[2];
        btnL = mask[1];
        btnR = mask[0];
    endtask

    task automatic clear_map();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) wall_map[y][x] = 1'b0;
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"}, player_x, m_x);
        check({tag, "_y"}, player_y, m_y);
        check({tag, "_count"}, move_count, m_cnt);
        check({tag, "_won"}, won, m_won);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_x = 0; m_y = 0; m_cnt = 0; m_won = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One button press (mask bits {U,D,L,R}), optionally preceded by chatter.
    task automatic press(input string tag, input logic [3:0] mask, input int hold, input int chatter);
        int   tx, ty, req0;
        logic exp_req;
        exp_req = 1'b0;
        tx = m_x;
        ty = m_y;
        if (!m_won) begin
            if (mask[3])      ty = ty - 1;
            else if (mask[2]) ty = ty + 1;
            else if (mask[1]) tx = tx - 1;
            else              tx = tx + 1;
            if (tx >= 0 && tx < GW && ty >= 0 && ty < GH) begin
                exp_req = 1'b1;
                if (!wall_map[ty][tx]) begin
                    m_x   = tx;
                    m_y   = ty;
                    m_cnt = (m_cnt + 1) % 65536;
                    if (tx == GOAL_X && ty == GOAL_Y) m_won = 1'b1;
                end
            end
        end
        req0 = req_total;
        for (int i = 0; i < chatter; i++) begin
            drive((i % 2 == 0) ? mask : 4'b0000);
            @(negedge clk);
        end
        drive(mask);
        repeat (hold) @(negedge clk);
        drive(4'b0000);
        repeat (DB + 12) @(negedge clk);
        check({tag, "_req_count"}, req_total - req0, exp_req ? 1 : 0);
        if (exp_req) begin
            check({tag, "_wall_x"}, last_wx, tx);
            check({tag, "_wall_y"}, last_wy, ty);
        end
        check_pos(tag);
    endtask

    task automatic glitch(input int len);
        int req0;
        req0 = req_total;
        drive(4'b0001);
        repeat (len) @(negedge clk);
        drive(4'b0000);
        repeat (DB + 12) @(negedge clk);
        check("glitch_req_count", req_total - req0, 0);
        check_pos("glitch");
    endtask

    // Waits for a wall_req strobe after a raw press; returns polls taken.
    task automatic wait_req(output int n, output logic found);
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            if (wall_req) found = 1'b1;
        end
    endtask

    initial begin
        int   n, req0;
        logic found;

        clear_map();
        m_x = 0; m_y = 0; m_cnt = 0; m_won = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_player_x", player_x, 0);
        check("rst_player_y", player_y, 0);
        check("rst_move_count", move_count, 0);
        check("rst_won", won, 0);
        check("rst_wall_req", wall_req, 0);
        check("rst_wall_x", wall_x, 0);
        check("rst_wall_y", wall_y, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while the wall answer is pending: no move may survive.
        drive(4'b0001);
        wait_req(n, found);
        check("rstwait_req_seen", found, 1);
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0000);
        #1;
        check("rstwait_player_x", player_x, 0);
        check("rstwait_count", move_count, 0);
        check("rstwait_wall_req", wall_req, 0);
        check("rstwait_wall_x", wall_x, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (DB + 12) @(negedge clk);
        check_pos("rstwait_after");

        // Clean btnR from (0,0): exact query and commit timing.
        req0 = req_total;
        drive(4'b0001);
        wait_req(n, found);
        check("timing_req_latency_ok", found && n >= DB + 1 && n <= DB + 5, 1);
        check("timing_wall_x", wall_x, 1);
        check("timing_wall_y", wall_y, 0);
        @(negedge clk);
        check("timing_req_one_cycle", wall_req, 0);
        check("timing_not_yet_moved", player_x, 0);
        @(negedge clk);
        check("timing_moved_x", player_x, 1);
        check("timing_moved_count", move_count, 1);
        repeat (DB + 12) @(negedge clk);
        drive(4'b0000);
        repeat (DB + 12) @(negedge clk);
        check("timing_hold_single_req", req_total - req0, 1);
        m_x = 1; m_cnt = 1;
        check_pos("timing_after");

        wall_map[1][1] = 1'b1;
        press("down_into_wall", 4'b0100, DB + 6, 0);
        press("up_at_top_edge", 4'b1000, DB + 6, 0);
        press("left_open", 4'b0010, DB + 6, 0);
        press("left_at_left_edge", 4'b0010, DB + 6, 0);
        press("right_open", 4'b0001, DB + 6, 0);
        wall_map[1][1] = 1'b0;
        press("down_open", 4'b0100, DB + 6, 0);
        press("up_and_right", 4'b1001, DB + 6, 0);

        for (int g = 1; g <= 3; g++) glitch(g);
        press("chatter_then_hold", 4'b0001, DB + 8, 10);

        // Random walls and button combinations.
        reset_dut();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) wall_map[y][x] = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 40; i++)
            press("rand", 4'($urandom_range(1, 15)), DB + 4 + int'($urandom_range(0, 10)), 0);

        // Open path to the goal, then the terminal state ignores presses.
        reset_dut();
        clear_map();
        for (int i = 0; i < GOAL_X; i++) press("path_right", 4'b0001, DB + 6, 0);
        for (int i = 0; i < GOAL_Y; i++) press("path_down", 4'b0100, DB + 6, 0);
        check("goal_won", won, 1);
        press("after_win_up", 4'b1000, DB + 6, 0);
        press("after_win_left", 4'b0010, DB + 6, 0);
        press("after_win_right", 4'b0001, DB + 6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
